framed_shiftregister: RTL and testbench



---
 rtl/framed_shiftregister_pkg.sv | 13 +
 rtl/frame_bit_counter.sv | 28 ++
 rtl/framed_shiftregister.sv | 97 +++++++++
 tb/tb_framed_shiftregister.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/framed_shiftregister_pkg.sv
// Shared types and constants for the framed shift register: FSM states and bit-order modes.
package framed_shiftregister_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/frame_bit_counter.sv
// Per-word shift counter: counts enabled shifts up to WIDTH, never wraps, flags terminal count.
module frame_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] TC = CW'(WIDTH);

  assign terminal = (count == TC);

  // Saturating at WIDTH keeps the count meaningful even if enable is held past the end of a word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && !terminal)
      count <= count + CW'(1);
  end

endmodule

// File: rtl/framed_shiftregister.sv
// Framed parallel-load / serial-shift register with selectable bit order, word counter and done pulse.
module framed_shiftregister
  import framed_shiftregister_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             peripheralClkEdge,
  input  logic             parallelLoad,
  input  logic [WIDTH-1:0] parallelDataIn,
  input  logic             serialDataIn,
  input  logic             lsbFirst,
  input  logic             holdShift,
  output logic [WIDTH-1:0] parallelDataOut,
  output logic             serialDataOut,
  output logic [CW-1:0]    bitCount,
  output logic             busy,
  output logic             wordDone
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mem;
  logic             mode;
  state_t           state;
  state_t           stateNext;
  logic             shiftReq;
  logic             memShift;
  logic             cntEn;
  logic             cntClr;
  logic             cntTerminal;

  function automatic logic [WIDTH-1:0] shiftWord(input logic [WIDTH-1:0] word,
                                                 input logic sin, input logic lsb);
    if (lsb == LSB_FIRST)
      return {sin, word[WIDTH-1:1]};
    else
      return {word[WIDTH-2:0], sin};
  endfunction

  // A load always wins; a strobe in DONE is dropped so the completed word stays intact for one cycle.
  assign shiftReq = peripheralClkEdge & ~holdShift & ~parallelLoad;
  assign memShift = shiftReq & (state != DONE);
  assign cntEn    = shiftReq & (state == SHIFT);
  assign cntClr   = parallelLoad | (state == DONE);

  always_comb begin
    stateNext = state;
    if (parallelLoad)
      stateNext = SHIFT;
    else begin
      case (state)
        IDLE:    stateNext = IDLE;
        SHIFT:   if (cntEn && bitCount == LAST) stateNext = DONE;
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mode  <= MSB_FIRST;
      mem   <= '0;
    end else begin
      state <= stateNext;
      if (parallelLoad) begin
        mode <= lsbFirst;
        mem  <= parallelDataIn;
      end else if (memShift) begin
        mem <= shiftWord(mem, serialDataIn, mode);
      end
    end
  end

  frame_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) uCounter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cntClr),
    .enable   (cntEn),
    .count    (bitCount),
    .terminal (cntTerminal)
  );

  assign parallelDataOut = mem;
  assign serialDataOut   = (mode == LSB_FIRST) ? mem[0] : mem[WIDTH-1];
  assign busy            = (state == SHIFT);
  // DONE is entered only from the WIDTH-th shift, so the counter is at terminal count here.
  assign wordDone        = (state == DONE) & cntTerminal;

endmodule

// File: tb/tb_framed_shiftregister.sv
// Bench for framed_shiftregister: directed vector table, corner-case sequences and random run vs a word-level model.
module tb_framed_shiftregister;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          peripheralClkEdge = 1'b0;
  logic          parallelLoad = 1'b0;
  logic [W-1:0]  parallelDataIn = '0;
  logic          serialDataIn = 1'b0;
  logic          lsbFirst = 1'b0;
  logic          holdShift = 1'b0;
  logic [W-1:0]  parallelDataOut;
  logic          serialDataOut;
  logic [CW-1:0] bitCount;
  logic          busy;
  logic          wordDone;

  framed_shiftregister #(.WIDTH(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .peripheralClkEdge (peripheralClkEdge),
    .parallelLoad      (parallelLoad),
    .parallelDataIn    (parallelDataIn),
    .serialDataIn      (serialDataIn),
    .lsbFirst          (lsbFirst),
    .holdShift         (holdShift),
    .parallelDataOut   (parallelDataOut),
    .serialDataOut     (serialDataOut),
    .bitCount          (bitCount),
    .busy              (busy),
    .wordDone          (wordDone)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int doneSeen = 0;

  // Word-level reference: integer word, shift count and flags.
  int mMem, mCnt;
  bit mLsb, mInWord, mDonePulse;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMem = 0; mCnt = 0; mLsb = 0; mInWord = 0; mDonePulse = 0;
  endtask

  task automatic modelStep();
    if (parallelLoad) begin
      mMem = int'(parallelDataIn); mLsb = lsbFirst; mCnt = 0;
      mInWord = 1; mDonePulse = 0;
    end else if (mDonePulse) begin
      mDonePulse = 0; mCnt = 0;
    end else if (peripheralClkEdge && !holdShift) begin
      if (mLsb) mMem = (mMem / 2) + (int'(serialDataIn) << (W - 1));
      else      mMem = ((mMem * 2) % (1 << W)) + int'(serialDataIn);
      if (mInWord) begin
        mCnt++;
        if (mCnt == W) begin mInWord = 0; mDonePulse = 1; end
      end
    end
  endtask

  task automatic checkModel(input string tag);
    int sdo;
    sdo = mLsb ? (mMem % 2) : ((mMem >> (W - 1)) % 2);
    chk({tag, ".pdo"},  int'(parallelDataOut), mMem);
    chk({tag, ".sdo"},  int'(serialDataOut), sdo);
    chk({tag, ".cnt"},  int'(bitCount), mCnt);
    chk({tag, ".busy"}, int'(busy), int'(mInWord));
    chk({tag, ".done"}, int'(wordDone), int'(mDonePulse));
  endtask

  task automatic setIn(input bit pl, input logic [W-1:0] pd, input bit stb,
                       input bit sin, input bit lsb, input bit hold);
    parallelLoad = pl; parallelDataIn = pd; peripheralClkEdge = stb;
    serialDataIn = sin; lsbFirst = lsb; holdShift = hold;
  endtask

  // One clock: model follows the inputs present at the edge, outputs sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    modelStep();
    #1;
    if (wordDone) doneSeen++;
  endtask

  task automatic idle();
    setIn(0, '0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit pl; logic [W-1:0] pd; bit stb; bit sin; bit lsb; bit hold;
    logic [W-1:0] ePdo; bit eSdo; int eCnt; bit eBusy; bit eDone;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(bit pl, logic [W-1:0] pd, bit stb, bit sin, bit lsb, bit hold,
                              logic [W-1:0] ePdo, bit eSdo, int eCnt, bit eBusy, bit eDone);
    vec_t v;
    v.pl = pl; v.pd = pd; v.stb = stb; v.sin = sin; v.lsb = lsb; v.hold = hold;
    v.ePdo = ePdo; v.eSdo = eSdo; v.eCnt = eCnt; v.eBusy = eBusy; v.eDone = eDone;
    return v;
  endfunction

  initial begin
    logic [W-1:0] seq;
    reset = 1'b1;
    modelReset();
    tbl[0] = mk(1, 8'hA5, 0, 0, 0, 0, 8'hA5, 1, 0, 1, 0);
    tbl[1] = mk(0, 8'h00, 1, 1, 0, 0, 8'h4B, 0, 1, 1, 0);
    tbl[2] = mk(0, 8'h00, 1, 1, 0, 0, 8'h97, 1, 2, 1, 0);
    tbl[3] = mk(0, 8'h00, 1, 0, 0, 0, 8'h2E, 0, 3, 1, 0);
    tbl[4] = mk(0, 8'h00, 1, 0, 0, 0, 8'h5C, 0, 4, 1, 0);
    tbl[5] = mk(0, 8'h00, 1, 0, 0, 0, 8'hB8, 1, 5, 1, 0);
    tbl[6] = mk(0, 8'h00, 1, 0, 0, 0, 8'h70, 0, 6, 1, 0);
    tbl[7] = mk(0, 8'h00, 1, 1, 0, 0, 8'hE1, 1, 7, 1, 0);
    tbl[8] = mk(0, 8'h00, 1, 1, 0, 0, 8'hC3, 1, 8, 0, 1);
    tbl[9] = mk(0, 8'h00, 0, 0, 0, 0, 8'hC3, 1, 0, 0, 0);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pdo", int'(parallelDataOut), 0);
    chk("rst.cnt", int'(bitCount), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(wordDone), 0);
    chk("rst.sdo", int'(serialDataOut), 0);
    reset = 1'b0;

    // MSB-first directed table
    doneSeen = 0;
    foreach (tbl[i]) begin
      setIn(tbl[i].pl, tbl[i].pd, tbl[i].stb, tbl[i].sin, tbl[i].lsb, tbl[i].hold);
      cyc();
      chk($sformatf("msb[%0d].pdo", i), int'(parallelDataOut), int'(tbl[i].ePdo));
      chk($sformatf("msb[%0d].sdo", i), int'(serialDataOut), int'(tbl[i].eSdo));
      chk($sformatf("msb[%0d].cnt", i), int'(bitCount), tbl[i].eCnt);
      chk($sformatf("msb[%0d].busy", i), int'(busy), int'(tbl[i].eBusy));
      chk($sformatf("msb[%0d].done", i), int'(wordDone), int'(tbl[i].eDone));
    end
    chk("msb.donecount", doneSeen, 1);

    // LSB-first: collect serialDataOut before each strobe
    setIn(1, 8'hA5, 0, 0, 1, 0); cyc();
    seq = '0;
    for (int i = 0; i < W; i++) begin
      seq[W-1-i] = serialDataOut;
      setIn(0, '0, 1, 0, 0, 0); cyc();
    end
    idle();
    chk("lsb.sdoseq", int'(seq), 'hA5);
    chk("lsb.pdo", int'(parallelDataOut), 0);
    chk("lsb.done", int'(wordDone), 1);
    cyc();

    // holdShift freezes mid-word
    doneSeen = 0;
    setIn(1, 8'hFF, 0, 0, 0, 0); cyc();
    repeat (3) begin setIn(0, '0, 1, 0, 0, 0); cyc(); end
    repeat (2) begin
      setIn(0, '0, 1, 0, 0, 1); cyc();
      chk("hold.cnt", int'(bitCount), 3);
      chk("hold.pdo", int'(parallelDataOut), 'hF8);
    end
    repeat (5) begin setIn(0, '0, 1, 0, 0, 0); cyc(); end
    idle();
    chk("hold.endcnt", int'(bitCount), 8);
    cyc(); cyc();
    chk("hold.donecount", doneSeen, 1);

    // Load colliding with a strobe mid-word
    setIn(1, 8'h00, 0, 0, 0, 0); cyc();
    repeat (5) begin setIn(0, '0, 1, 1, 0, 0); cyc(); end
    chk("coll.cnt5", int'(bitCount), 5);
    setIn(1, 8'h3C, 1, 1, 0, 0); cyc();
    chk("coll.cnt", int'(bitCount), 0);
    chk("coll.pdo", int'(parallelDataOut), 'h3C);
    chk("coll.busy", int'(busy), 1);

    // Load during DONE: back-to-back words
    doneSeen = 0;
    repeat (W) begin setIn(0, '0, 1, 0, 0, 0); cyc(); end
    chk("b2b.done", int'(wordDone), 1);
    setIn(1, 8'h55, 0, 0, 0, 0); cyc();
    chk("b2b.busy", int'(busy), 1);
    chk("b2b.cnt", int'(bitCount), 0);
    chk("b2b.pdo", int'(parallelDataOut), 'h55);
    idle(); cyc();
    chk("b2b.donecount", doneSeen, 1);

    // Asynchronous reset mid-word
    repeat (4) begin setIn(0, '0, 1, 1, 0, 0); cyc(); end
    idle();
    chk("arst.pre", int'(bitCount), 4);
    #2 reset = 1'b1;
    #1;
    chk("arst.pdo", int'(parallelDataOut), 0);
    chk("arst.cnt", int'(bitCount), 0);
    chk("arst.busy", int'(busy), 0);
    chk("arst.done", int'(wordDone), 0);
    chk("arst.sdo", int'(serialDataOut), 0);
    modelReset();
    @(posedge clk); #1 reset = 1'b0;
    doneSeen = 0;
    repeat (10) begin setIn(0, '0, 1, 0, 0, 0); cyc(); end
    chk("arst.nodone", doneSeen, 0);
    checkModel("arst.model");

    // Randomised run against the model
    for (int i = 0; i < 3000; i++) begin
      setIn($urandom_range(0, 11) == 0, W'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
      cyc();
      checkModel("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
